// File: rtl/exe_stage.sv
// exe_stage: ALU and branch resolution with a registered EXE/MEM valid/ready boundary,
// one-cycle fetch redirect, and a fixed-length squash window after taken control transfers.
module exe_stage #(
    parameter int DATA_WIDTH  = 32,
    parameter int REG_LENGTH  = 5,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  reg_write_e,
    input  logic                  mem_read_e,
    input  logic                  mem_write_e,
    input  logic                  jal_e,
    input  logic                  jalr_e,
    input  logic                  beq_e,
    input  logic                  bne_e,
    input  logic                  blt_e,
    input  logic                  bge_e,
    input  logic                  br_unsigned_e,
    input  logic [3:0]            alu_op_e,
    input  logic                  alu_src_a_e,
    input  logic                  alu_src_b_e,
    input  logic [DATA_WIDTH-1:0] rd1_e,
    input  logic [DATA_WIDTH-1:0] rd2_e,
    input  logic [DATA_WIDTH-1:0] pc_e,
    input  logic [DATA_WIDTH-1:0] imm_e,
    input  logic [REG_LENGTH-1:0] rd_e,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] alu_result_m,
    output logic [DATA_WIDTH-1:0] write_data_m,
    output logic [REG_LENGTH-1:0] rd_m,
    output logic                  reg_write_m,
    output logic                  mem_read_m,
    output logic                  mem_write_m,
    output logic                  redirect,
    output logic [DATA_WIDTH-1:0] redirect_pc
);
    localparam int SW = $clog2(DATA_WIDTH);

    typedef enum logic {RUN, SQUASH} state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic [DATA_WIDTH-1:0] a, b, alu, result, target;
    logic [SW-1:0]         sh;
    logic                  eq, lt, taken, accept;

    assign in_ready = (state == SQUASH) | ~out_valid | out_ready;
    assign accept   = (state == RUN) & in_valid & in_ready;

    always_comb begin
        a   = alu_src_a_e ? pc_e : rd1_e;
        b   = alu_src_b_e ? imm_e : rd2_e;
        sh  = b[SW-1:0];
        alu = '0;
        case (alu_op_e)
            4'd0:    alu = a + b;
            4'd1:    alu = a - b;
            4'd2:    alu = a & b;
            4'd3:    alu = a | b;
            4'd4:    alu = a ^ b;
            4'd5:    alu = a << sh;
            4'd6:    alu = a >> sh;
            4'd7:    alu = $unsigned($signed(a) >>> sh);
            4'd8:    alu = DATA_WIDTH'($signed(a) < $signed(b));
            4'd9:    alu = DATA_WIDTH'(a < b);
            4'd10:   alu = b;
            default: alu = '0;
        endcase
        eq     = rd1_e == rd2_e;
        lt     = br_unsigned_e ? (rd1_e < rd2_e) : ($signed(rd1_e) < $signed(rd2_e));
        // Only the highest-priority flag decides; lower flags are ignored entirely.
        taken  = jal_e | jalr_e | (beq_e ? eq : bne_e ? ~eq : blt_e ? lt : bge_e & ~lt);
        target = (jalr_e & ~jal_e) ? ((rd1_e + imm_e) & ~DATA_WIDTH'(1)) : pc_e + imm_e;
        result = (jal_e | jalr_e) ? pc_e + DATA_WIDTH'(4) : alu;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            cnt          <= '0;
            out_valid    <= 1'b0;
            alu_result_m <= '0;
            write_data_m <= '0;
            rd_m         <= '0;
            reg_write_m  <= 1'b0;
            mem_read_m   <= 1'b0;
            mem_write_m  <= 1'b0;
            redirect     <= 1'b0;
            redirect_pc  <= '0;
        end else begin
            redirect <= accept & taken;
            if (accept & taken) begin
                redirect_pc <= target;
                state       <= SQUASH;
                cnt         <= 4'(FLUSH_DEPTH);
            end else if (state == SQUASH) begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) state <= RUN;
            end
            if (accept) begin
                out_valid    <= 1'b1;
                alu_result_m <= result;
                write_data_m <= rd2_e;
                rd_m         <= rd_e;
                reg_write_m  <= reg_write_e;
                mem_read_m   <= mem_read_e;
                mem_write_m  <= mem_write_e;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: scoreboard bench for exe_stage; expected outputs and redirect targets
// are computed from a behavioural model when beats are sent and checked when they emerge.
module tb_exe_stage;
    localparam int DW = 32;
    localparam int RL = 5;
    localparam int FD = 2;

    logic          clk = 0, reset = 1, in_valid = 0, in_ready, out_valid, out_ready = 1;
    logic          reg_write_e, mem_read_e, mem_write_e, jal_e, jalr_e, beq_e, bne_e, blt_e, bge_e;
    logic          br_unsigned_e, alu_src_a_e, alu_src_b_e;
    logic [3:0]    alu_op_e;
    logic [DW-1:0] rd1_e, rd2_e, pc_e, imm_e, alu_result_m, write_data_m, redirect_pc;
    logic [RL-1:0] rd_e, rd_m;
    logic          reg_write_m, mem_read_m, mem_write_m, redirect;

    typedef struct packed {
        logic rw, mr, mw, jal, jalr, beq, bne, blt, bge, bu;
        logic [3:0] op;
        logic sa, sb;
        logic [31:0] rd1, rd2, pc, imm;
        logic [4:0] rd;
    } beat_t;

    typedef struct packed {
        logic [31:0] res, wd;
        logic [4:0] rd;
        logic rw, mr, mw;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] rq[$];
    int          total = 0, bad = 0;
    logic        prev_red = 0;
    exp_t        got, e;
    logic [31:0] r;

    exe_stage #(.DATA_WIDTH(DW), .REG_LENGTH(RL), .FLUSH_DEPTH(FD)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .reg_write_e(reg_write_e), .mem_read_e(mem_read_e), .mem_write_e(mem_write_e),
        .jal_e(jal_e), .jalr_e(jalr_e), .beq_e(beq_e), .bne_e(bne_e), .blt_e(blt_e), .bge_e(bge_e),
        .br_unsigned_e(br_unsigned_e), .alu_op_e(alu_op_e), .alu_src_a_e(alu_src_a_e),
        .alu_src_b_e(alu_src_b_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .pc_e(pc_e), .imm_e(imm_e),
        .rd_e(rd_e), .out_valid(out_valid), .out_ready(out_ready), .alu_result_m(alu_result_m),
        .write_data_m(write_data_m), .rd_m(rd_m), .reg_write_m(reg_write_m),
        .mem_read_m(mem_read_m), .mem_write_m(mem_write_m), .redirect(redirect),
        .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic logic taken_of(beat_t b);
        logic lt;
        lt = b.bu ? (b.rd1 < b.rd2) : ($signed(b.rd1) < $signed(b.rd2));
        if (b.jal || b.jalr) return 1'b1;
        if (b.beq) return b.rd1 == b.rd2;
        if (b.bne) return b.rd1 != b.rd2;
        if (b.blt) return lt;
        if (b.bge) return !lt;
        return 1'b0;
    endfunction

    function automatic logic [31:0] target_of(beat_t b);
        logic [31:0] t;
        if (!b.jal && b.jalr) begin
            t = b.rd1 + b.imm;
            t[0] = 1'b0;
            return t;
        end
        return b.pc + b.imm;
    endfunction

    function automatic exp_t model(beat_t b);
        exp_t        x;
        logic [31:0] a, bb;
        int          s;
        a  = b.sa ? b.pc : b.rd1;
        bb = b.sb ? b.imm : b.rd2;
        s  = int'(bb[4:0]);
        case (b.op)
            0:  x.res = a + bb;
            1:  x.res = a - bb;
            2:  x.res = a & bb;
            3:  x.res = a | bb;
            4:  x.res = a ^ bb;
            5:  x.res = a << s;
            6:  x.res = a >> s;
            7:  x.res = $unsigned($signed(a) >>> s);
            8:  x.res = ($signed(a) < $signed(bb)) ? 32'd1 : 32'd0;
            9:  x.res = (a < bb) ? 32'd1 : 32'd0;
            10: x.res = bb;
            default: x.res = 32'd0;
        endcase
        if (b.jal || b.jalr) x.res = b.pc + 32'd4;
        x.wd = b.rd2;
        x.rd = b.rd;
        x.rw = b.rw;
        x.mr = b.mr;
        x.mw = b.mw;
        return x;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (redirect) begin
                total++;
                if (rq.size() == 0) begin
                    bad++;
                    $display("FAIL redirect_unexpected: got redirect_pc=%h, required no redirect", redirect_pc);
                end else begin
                    r = rq.pop_front();
                    if (redirect_pc !== r) begin
                        bad++;
                        $display("FAIL redirect_pc: got %h required %h", redirect_pc, r);
                    end
                end
                total++;
                if (prev_red) begin
                    bad++;
                    $display("FAIL redirect_consecutive: got redirect=1 two cycles running, required single pulse");
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                total++;
                got = {alu_result_m, write_data_m, rd_m, reg_write_m, mem_read_m, mem_write_m};
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL output_unexpected: got result=%h, required no output", alu_result_m);
                end else begin
                    e = sb.pop_front();
                    if (got !== e) begin
                        bad++;
                        $display("FAIL output_beat: got res=%h wd=%h rd=%0d rw/mr/mw=%b%b%b required res=%h wd=%h rd=%0d rw/mr/mw=%b%b%b",
                                 got.res, got.wd, got.rd, got.rw, got.mr, got.mw, e.res, e.wd, e.rd, e.rw, e.mr, e.mw);
                    end
                end
            end
        end
        prev_red = reset ? 1'b0 : redirect;
    end

    task automatic drive(beat_t b);
        reg_write_e = b.rw; mem_read_e = b.mr; mem_write_e = b.mw;
        jal_e = b.jal; jalr_e = b.jalr; beq_e = b.beq; bne_e = b.bne; blt_e = b.blt; bge_e = b.bge;
        br_unsigned_e = b.bu; alu_op_e = b.op; alu_src_a_e = b.sa; alu_src_b_e = b.sb;
        rd1_e = b.rd1; rd2_e = b.rd2; pc_e = b.pc; imm_e = b.imm; rd_e = b.rd;
    endtask

    task automatic send(beat_t b, bit keep);
        int n = 0;
        drive(b);
        in_valid = 1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=%b required 1", in_ready);
        end
        if (keep) begin
            sb.push_back(model(b));
            if (taken_of(b)) rq.push_back(target_of(b));
        end
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(string name);
        int n = 0;
        while ((sb.size() != 0 || rq.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        idle(1);
        total++;
        if (sb.size() != 0 || rq.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: got %0d outputs and %0d redirects pending, required 0", name, sb.size(), rq.size());
        end
    endtask

    task automatic test_reset();
        beat_t b = '0;
        drive(b);
        reset = 1;
        idle(3);
        total++;
        if ({out_valid, redirect, alu_result_m, write_data_m, rd_m, reg_write_m, mem_read_m,
             mem_write_m, redirect_pc, in_ready} !== {1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 3'b000, 32'd0, 1'b1}) begin
            bad++;
            $display("FAIL reset_state: got out_valid=%b redirect=%b res=%h in_ready=%b required 0,0,0,1",
                     out_valid, redirect, alu_result_m, in_ready);
        end
        reset = 0;
        idle(1);
    endtask

    task automatic test_alu();
        beat_t b = '0;
        b.rd1 = 32'd5; b.imm = 32'd7; b.sb = 1; b.op = 4'd0; b.rd = 5'd3; b.rw = 1;
        send(b, 1);
        b = '0;
        b.rd1 = 32'h8000_0000; b.imm = 32'd4; b.sb = 1; b.op = 4'd7; b.rd = 5'd4;
        send(b, 1);
        for (int i = 0; i < 30; i++) begin
            b = '0;
            b.op = 4'($urandom_range(0, 15));
            b.rd1 = $urandom; b.rd2 = $urandom; b.imm = $urandom; b.pc = $urandom;
            if (i % 3 == 0) b.rd2 = b.rd1;
            b.sa = 1'($urandom); b.sb = 1'($urandom); b.bu = 1'($urandom);
            b.rd = 5'($urandom); b.rw = 1'($urandom); b.mr = 1'($urandom); b.mw = 1'($urandom);
            send(b, 1);
        end
        drain("alu");
    endtask

    task automatic test_backpressure();
        beat_t a = '0, b = '0;
        exp_t  ea;
        a.rd1 = 32'd100; a.rd2 = 32'd58; a.op = 4'd1; a.rd = 5'd9; a.mw = 1;
        b.rd1 = 32'hF0; b.rd2 = 32'h0F; b.op = 4'd3; b.rd = 5'd10; b.rw = 1;
        ea = model(a);
        out_ready = 0;
        send(a, 1);
        drive(b);
        in_valid = 1;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || alu_result_m !== ea.res || rd_m !== ea.rd) begin
                bad++;
                $display("FAIL stall_hold: got in_ready=%b out_valid=%b res=%h rd=%0d required 0,1,%h,%0d",
                         in_ready, out_valid, alu_result_m, rd_m, ea.res, ea.rd);
            end
        end
        sb.push_back(model(b));
        @(posedge clk);
        #1 out_ready = 1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL stall_release: got in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 0;
        drain("backpressure");
    endtask

    task automatic test_branch_squash();
        beat_t b = '0;
        b.beq = 1; b.pc = 32'h8000_0010; b.imm = 32'hFFFF_FFF8; b.rd1 = 32'd3; b.rd2 = 32'd3; b.rd = 5'd1;
        send(b, 1);
        send(b, 0);
        b = '0;
        b.rd1 = 32'd1; b.rd2 = 32'd2; b.rd = 5'd2; b.rw = 1;
        send(b, 0);
        b.rd1 = 32'd10; b.rd2 = 32'd20; b.rd = 5'd5;
        send(b, 1);
        drain("branch_squash");
    endtask

    task automatic test_jalr();
        beat_t b = '0;
        b.jalr = 1; b.rd1 = 32'h8000_0101; b.imm = 32'd4; b.pc = 32'h8000_0020; b.rw = 1; b.rd = 5'd1;
        b.op = 4'd4;
        send(b, 1);
        idle(FD + 1);
        drain("jalr");
    endtask

    task automatic test_blt_priority();
        beat_t b = '0;
        b.blt = 1; b.rd1 = 32'hFFFF_FFFF; b.rd2 = 32'd1; b.pc = 32'h200; b.imm = 32'h10; b.rd = 5'd6;
        send(b, 1);
        idle(FD + 1);
        b.bu = 1;
        send(b, 1);
        b = '0;
        b.jal = 1; b.jalr = 1; b.rd1 = 32'h1000; b.imm = 32'h8; b.pc = 32'h40; b.rd = 5'd7; b.rw = 1;
        send(b, 1);
        idle(FD + 1);
        b = '0;
        b.beq = 1; b.bne = 1; b.rd1 = 32'd4; b.rd2 = 32'd5; b.pc = 32'h300; b.imm = 32'h20;
        send(b, 1);
        b = '0;
        b.bge = 1; b.rd1 = 32'h8000_0000; b.rd2 = 32'h8000_0000; b.pc = 32'h400; b.imm = 32'hFFFF_FFF0;
        send(b, 1);
        idle(FD + 1);
        drain("blt_priority");
    endtask

    task automatic test_reset_in_squash();
        beat_t b = '0;
        out_ready = 0;
        b.jal = 1; b.pc = 32'h100; b.imm = 32'h40; b.rd = 5'd7; b.rw = 1;
        send(b, 1);
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL squash_ready: got in_ready=%b out_valid=%b required 1,1", in_ready, out_valid);
        end
        @(posedge clk);
        #1 reset = 1;
        @(posedge clk);
        #1;
        total++;
        if ({out_valid, redirect, alu_result_m, write_data_m, rd_m, reg_write_m, mem_read_m,
             mem_write_m, redirect_pc, in_ready} !== {1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 3'b000, 32'd0, 1'b1}) begin
            bad++;
            $display("FAIL reset_mid_squash: got out_valid=%b redirect=%b res=%h rd=%0d in_ready=%b required 0,0,0,0,1",
                     out_valid, redirect, alu_result_m, rd_m, in_ready);
        end
        sb.delete();
        rq.delete();
        reset = 0;
        out_ready = 1;
        b = '0;
        b.rd1 = 32'd21; b.imm = 32'd21; b.sb = 1; b.rd = 5'd11; b.rw = 1;
        send(b, 1);
        drain("reset_squash");
    endtask

    initial begin
        test_reset();
        test_alu();
        test_backpressure();
        test_branch_squash();
        test_jalr();
        test_blt_priority();
        test_reset_in_squash();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
Execute stage directly downstream of the ID/EXE pipeline register. It consumes the decoded operands and controls, computes the ALU result, and resolves jal/jalr/conditional branches. It registers results into the EXE/MEM boundary with a valid/ready handshake, issues a one-cycle PC redirect, and squashes wrong-path beats for a fixed number of cycles after a taken control transfer.

Parameters:
DATA_WIDTH, 32, datapath width; shift amount uses the low log2(DATA_WIDTH) bits of operand B.
REG_LENGTH, 5, register index width.
FLUSH_DEPTH, 2, number of cycles spent in SQUASH after a taken control transfer (1..15).

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  ID/EXE holds a valid instruction.
in_ready  out  1  stage accepts the instruction this cycle.
reg_write_e, mem_read_e, mem_write_e  in  1  controls passed through to MEM.
jal_e, jalr_e, beq_e, bne_e, blt_e, bge_e  in  1  control-transfer type.
br_unsigned_e  in  1  blt/bge compare unsigned when 1, signed when 0.
alu_op_e  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 PASS_B; other codes give 0.
alu_src_a_e  in  1  0 selects rd1_e, 1 selects pc_e.
alu_src_b_e  in  1  0 selects rd2_e, 1 selects imm_e.
rd1_e, rd2_e, pc_e, imm_e  in  DATA_WIDTH  operands, PC and sign-extended immediate.
rd_e  in  REG_LENGTH  destination register.
out_valid  out  1  EXE/MEM register holds a valid result.
out_ready  in  1  MEM accepts the result.
alu_result_m, write_data_m  out  DATA_WIDTH  result (pc+4 for jal/jalr) and store data (rd2_e).
rd_m  out  REG_LENGTH; reg_write_m, mem_read_m, mem_write_m  out  1  registered pass-through.
redirect  out  1  one-cycle pulse requesting a fetch redirect.
redirect_pc  out  DATA_WIDTH  redirect target, valid when redirect=1.

Behaviour:
- Reset (reset=1 at edge, including mid-operation): out_valid=0, redirect=0, every data/control output=0, state=RUN, squash counter=0.
- in_ready = (state==SQUASH) | ~out_valid | out_ready. This is combinational with no in_valid dependency.
- Accept (RUN & in_valid & in_ready): on the edge, load all _m outputs and set out_valid=1. Result is visible one cycle after acceptance.
- Drain: out_valid & out_ready with no accept → out_valid=0 next cycle; data outputs hold their last value.
- Stall: out_valid & ~out_ready → every _m output and out_valid held stable.
- Arithmetic: all results are modulo 2^DATA_WIDTH.
  - SRA is arithmetic.
  - SLT is a signed compare; SLTU is an unsigned compare.
  - Set results are zero-extended to 1.
- Taken decision, with priority jal > jalr > beq > bne > blt > bge; only the highest-priority asserted flag is used:
  - beq: rd1 == rd2.
  - bne: rd1 != rd2.
  - blt: rd1 < rd2, signed or unsigned per br_unsigned_e.
  - bge: rd1 >= rd2, signed or unsigned per br_unsigned_e.
- Targets:
  - jalr: (rd1_e + imm_e) with bit 0 cleared.
  - All others: pc_e + imm_e.
- jal/jalr: alu_result_m = pc_e + 4, independent of alu_op_e.
- Accepted taken transfer: redirect=1 and redirect_pc=target on the next cycle for exactly one cycle, independent of out_ready. The state moves to SQUASH with counter = FLUSH_DEPTH.
- Not-taken branch: passes through normally with no redirect.
- SQUASH state:
  - in_ready=1, and any in_valid beat is consumed and discarded.
  - A taken branch in SQUASH produces no redirect.
  - The counter decrements every cycle; when it reaches 1 the state returns to RUN on the next edge.
  - The output register still drains and stalls normally.
- redirect is registered and never asserted in two consecutive cycles.

Test Plan:
1. ADD: rd1_e=5, imm_e=7, alu_src_b_e=1, op=0, in_valid=1, out_ready=1 → next cycle out_valid=1, alu_result_m=12; SRA of 0x80000000 by 4 → 0xF8000000.
2. Backpressure: out_valid=1, out_ready=0 for 3 cycles while in_valid=1 → in_ready=0, outputs unchanged. Raise out_ready → pending beat loaded on that edge.
3. beq taken: pc=0x80000010, imm=0xFFFFFFF8, rd1=rd2=3 → redirect=1 for one cycle, redirect_pc=0x80000008. The next 2 input beats are dropped with no out_valid for them; the 3rd beat appears at the output.
4. jalr: rd1=0x80000101, imm=4, pc=0x80000020, reg_write_e=1 → redirect_pc=0x80000104, alu_result_m=0x80000024, reg_write_m=1.
5. blt with rd1=0xFFFFFFFF, rd2=1: br_unsigned=0 → redirect; br_unsigned=1 → no redirect, beat passes to output.
6. reset=1 while in SQUASH with out_valid=1 → next cycle all outputs 0, in_ready=1. A beat presented after release is accepted and appears at the output.
